// File: rtl/out_pack.sv
// Packs PACK_N consecutive DATA_W-bit samples LSB-first into one registered output word.
// Optional even parity on o_data is enabled by defining OUT_PACK_PARITY_EN.
module out_pack #(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned PACK_N = 4,
  parameter int unsigned CNT_W  = $clog2(PACK_N) + 1
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic                     i_vld,
  input  logic [DATA_W-1:0]        i_data,
  output logic                     o_rdy,
  input  logic                     i_flush,
  output logic                     o_vld,
  output logic [DATA_W*PACK_N-1:0] o_data,
  output logic [CNT_W-1:0]         o_cnt,
  output logic                     o_par,
  input  logic                     i_rdy
);

  localparam int unsigned WordW = DATA_W * PACK_N;

  localparam logic StFill = 1'b0;
  localparam logic StFull = 1'b1;

  logic             state_q;
  logic [CNT_W-1:0] fill_q;
  logic [WordW-1:0] asm_q;
  logic [WordW-1:0] data_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept;
  logic             flush_act;
  logic             complete;
  logic [WordW-1:0] asm_w;
  logic [CNT_W-1:0] cnt_w;

  assign o_vld  = (state_q == StFull);
  assign o_rdy  = rst_b & (~o_vld | i_rdy);
  assign o_data = data_q;
  assign o_cnt  = cnt_q;

  assign accept    = i_vld & o_rdy;
  assign flush_act = i_flush & o_rdy;

  // Assembly word including the sample accepted this cycle, if any.
  always_comb begin
    asm_w = asm_q;
    for (int k = 0; k < PACK_N; k++) begin
      if (accept && (fill_q == CNT_W'(k))) begin
        asm_w[k*DATA_W +: DATA_W] = i_data;
      end
    end
    cnt_w    = fill_q + CNT_W'(accept);
    complete = (accept && (fill_q == CNT_W'(PACK_N - 1))) ||
               (flush_act && (cnt_w != '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= StFill;
      fill_q  <= '0;
      asm_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else if (complete) begin
      state_q <= StFull;
      data_q  <= asm_w;
      cnt_q   <= cnt_w;
      asm_q   <= '0;
      fill_q  <= '0;
    end else begin
      // While stalled in FULL no sample is accepted, so the assembly state is unchanged.
      asm_q  <= asm_w;
      fill_q <= cnt_w;
      if (i_rdy) begin
        state_q <= StFill;
      end
    end
  end

`ifdef OUT_PACK_PARITY_EN
  logic par_q;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      par_q <= 1'b0;
    end else if (complete) begin
      par_q <= ^asm_w;
    end
  end

  assign o_par = par_q;
`else
  assign o_par = 1'b0;
`endif

endmodule

// File: tb/tb_out_pack.sv
// Directed self-checking bench for out_pack (default DATA_W=5, PACK_N=4).
module tb_out_pack;

  localparam int unsigned DATA_W = 5;
  localparam int unsigned PACK_N = 4;
  localparam int unsigned CNT_W  = 3;

`ifdef OUT_PACK_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_b = 1'b0;
  logic                     i_vld = 1'b0;
  logic [DATA_W-1:0]        i_data = '0;
  logic                     o_rdy;
  logic                     i_flush = 1'b0;
  logic                     o_vld;
  logic [DATA_W*PACK_N-1:0] o_data;
  logic [CNT_W-1:0]         o_cnt;
  logic                     o_par;
  logic                     i_rdy = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  out_pack #(
    .DATA_W(DATA_W),
    .PACK_N(PACK_N),
    .CNT_W (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .i_vld  (i_vld),
    .i_data (i_data),
    .o_rdy  (o_rdy),
    .i_flush(i_flush),
    .o_vld  (o_vld),
    .o_data (o_data),
    .o_cnt  (o_cnt),
    .o_par  (o_par),
    .i_rdy  (i_rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    i_vld  = 1'b1;
    i_data = d;
    tick();
    i_vld  = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [19:0] exp_data,
                            input logic [CNT_W-1:0] exp_cnt);
    check({tag, "_vld"}, 32'(o_vld), 32'd1);
    check({tag, "_data"}, 32'(o_data), 32'(exp_data));
    check({tag, "_cnt"}, 32'(o_cnt), 32'(exp_cnt));
    check({tag, "_par"}, 32'(o_par), 32'(ParEn ? ^exp_data : 1'b0));
  endtask

  logic [DATA_W-1:0] q[$];
  logic [19:0]       exp_w;
  int                sent;
  int                words;

  initial begin
    // Reset
    tick();
    tick();
    check("rst_vld", 32'(o_vld), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_cnt", 32'(o_cnt), 32'd0);
    check("rst_par", 32'(o_par), 32'd0);
    check("rst_rdy", 32'(o_rdy), 32'd0);
    rst_b = 1'b1;
    i_rdy = 1'b1;
    tick();

    // Streaming: 1,2,3,4 back to back
    send(5'd1); send(5'd2); send(5'd3);
    check("stream_novld", 32'(o_vld), 32'd0);
    send(5'd4);
    check_word("stream", 20'h20C41, 3'd4);
    tick();
    check("stream_onecyc", 32'(o_vld), 32'd0);

    // Stall: complete a word with i_rdy=0, hold for 5 cycles with i_vld=1
    i_rdy = 1'b0;
    send(5'd5); send(5'd6); send(5'd7); send(5'd8);
    i_vld  = 1'b1;
    i_data = 5'd9;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_rdy", 32'(o_rdy), 32'd0);
      check_word("stall", 20'h41CC5, 3'd4);
      tick();
    end
    i_rdy = 1'b1;
    #1;
    check("release_rdy", 32'(o_rdy), 32'd1);
    tick();
    check("release_consumed", 32'(o_vld), 32'd0);
    send(5'd10); send(5'd11); send(5'd12);
    check_word("release", 20'h62D49, 3'd4);
    tick();

    // Partial flush
    send(5'h1F); send(5'h01);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check_word("flush2", 20'h0003F, 3'd2);
    tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("flush_empty", 32'(o_vld), 32'd0);
    tick();
    check("flush_empty2", 32'(o_vld), 32'd0);

    // Flush together with a sample; parity word 20'h00001
    i_flush = 1'b1;
    send(5'd1);
    i_flush = 1'b0;
    check_word("flush_sample", 20'h00001, 3'd1);
    tick();

    // Flush together with the PACK_N-th sample gives one full word
    send(5'd1); send(5'd2); send(5'd3);
    i_flush = 1'b1;
    send(5'd4);
    i_flush = 1'b0;
    check_word("flush_full", 20'h20C41, 3'd4);
    tick();
    check("flush_full_single", 32'(o_vld), 32'd0);

    // Flush ignored while o_rdy=0 and not remembered
    i_rdy = 1'b0;
    send(5'd1); send(5'd2); send(5'd3); send(5'd4);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_rdy   = 1'b1;
    tick();
    check("flush_ignored", 32'(o_vld), 32'd0);
    tick();
    check("flush_ignored2", 32'(o_vld), 32'd0);

    // Simultaneous consume and accept
    send(5'd1); send(5'd2); send(5'd3); send(5'd4);
    send(5'h0A);
    check("simul_consumed", 32'(o_vld), 32'd0);
    send(5'h0B); send(5'h0C); send(5'h0D);
    check_word("simul", 20'h6B16A, 3'd4);
    tick();

    // 64 random samples with random downstream backpressure
    sent  = 0;
    words = 0;
    for (int c = 0; c < 1000 && (sent < 64 || q.size() != 0 || o_vld); c++) begin
      i_vld  = (sent < 64);
      i_data = DATA_W'($urandom);
      i_rdy  = 1'($urandom);
      #1;
      if (o_vld && i_rdy) begin
        if (q.size() >= 4) begin
          exp_w = {q[3], q[2], q[1], q[0]};
          repeat (4) void'(q.pop_front());
        end else begin
          exp_w = '1;
        end
        check("rand_data", 32'(o_data), 32'(exp_w));
        check("rand_cnt", 32'(o_cnt), 32'd4);
        words++;
      end
      if (i_vld && o_rdy) begin
        q.push_back(i_data);
        sent++;
      end
      tick();
    end
    i_vld = 1'b0;
    i_rdy = 1'b1;
    check("rand_sent", 32'(sent), 32'd64);
    check("rand_words", 32'(words), 32'd16);
    check("rand_left", 32'(q.size()), 32'd0);
    tick();

    // Mid-word reset
    send(5'd1); send(5'd2); send(5'd3);
    rst_b = 1'b0;
    tick();
    check("mrst_vld", 32'(o_vld), 32'd0);
    check("mrst_data", 32'(o_data), 32'd0);
    check("mrst_cnt", 32'(o_cnt), 32'd0);
    check("mrst_par", 32'(o_par), 32'd0);
    check("mrst_rdy", 32'(o_rdy), 32'd0);
    rst_b = 1'b1;
    tick();
    send(5'h11); send(5'h12); send(5'h13);
    check("mrst_novld", 32'(o_vld), 32'd0);
    send(5'h14);
    check_word("mrst", 20'hA4E51, 3'd4);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
